// File: rtl/wave_pkg.sv
// wave_pkg: shared definitions for the waveform capture path and its display reader.
//   - wave_state_t       : capture FSM encoding (ARMED / ACTIVE / WAIT)
//   - width localparams  : RAM offset/address widths, audio and display sample widths
//   - to_display_sample  : signed 16-bit audio sample -> unsigned 8-bit display sample
package wave_pkg;

    localparam int WAVE_OFFSET_W = 8;
    localparam int WAVE_ADDR_W   = 9;
    localparam int SAMPLE_W      = 16;
    localparam int DISP_SAMPLE_W = 8;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } wave_state_t;

    // Flipping the sign bit turns two's complement into offset binary, so the
    // most negative input maps to 0 and zero maps to mid-scale (8'h80).
    function automatic logic [DISP_SAMPLE_W-1:0] to_display_sample(
        input logic [SAMPLE_W-1:0] s
    );
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2 -: DISP_SAMPLE_W-1]};
    endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// edge_detect_rise: registered rising-edge detector.
//   clk   : system clock
//   reset : synchronous, active-high; clears the history register to 0
//   level : level input to watch
//   rise  : high while level is 1 and its registered copy from last cycle is 0
module edge_detect_rise (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/wave_capture.sv
// wave_capture: arms on a positive-going zero crossing of the audio stream and
// writes 256 (optionally decimated) display samples into the half of a 512-entry
// double-buffered RAM that is not being displayed, then flips read_index on the
// next rising edge of wave_display_idle.
//   clk, reset         : system clock, synchronous active-high reset
//   new_sample_ready   : one-cycle strobe qualifying new_sample_in
//   new_sample_in      : signed 16-bit audio sample
//   wave_display_idle  : high while the display is outside its drawing region
//   write_address      : RAM write address {~read_index, offset}
//   write_enable       : one-cycle RAM write strobe
//   write_sample       : unsigned 8-bit display sample
//   read_index         : RAM half currently shown by the display
//   capturing          : high while the FSM is in ACTIVE
//
// Stream protocol: there is no back-pressure. new_sample_ready acts as a valid
// that is always accepted in the cycle it is high; the resulting RAM write
// (write_enable with its address and data) appears registered one cycle later.
module wave_capture
    import wave_pkg::*;
#(
    parameter int DECIMATE = 1,
    parameter int TIMEOUT  = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     new_sample_ready,
    input  logic [SAMPLE_W-1:0]      new_sample_in,
    input  logic                     wave_display_idle,
    output logic [WAVE_ADDR_W-1:0]   write_address,
    output logic                     write_enable,
    output logic [DISP_SAMPLE_W-1:0] write_sample,
    output logic                     read_index,
    output logic                     capturing
);

    // Counter only ever has to reach TIMEOUT-1.
    localparam int                TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam bit                TO_EN    = (TIMEOUT != 0);
    localparam logic [3:0]        DEC_LAST = 4'(DECIMATE - 1);

    wave_state_t                 state, state_next;
    logic [WAVE_OFFSET_W-1:0]    offset, offset_next;
    logic [3:0]                  decim_cnt, decim_next;
    logic [TO_W-1:0]             timeout_cnt, timeout_next;
    logic [SAMPLE_W-1:0]         prev_sample, prev_next;
    logic                        read_index_next;
    logic                        we_next;
    logic [WAVE_ADDR_W-1:0]      addr_next;
    logic [DISP_SAMPLE_W-1:0]    sample_next;
    logic                        idle_rise;
    logic                        trigger;
    logic                        forced;

    edge_detect_rise u_idle_edge (
        .clk   (clk),
        .reset (reset),
        .level (wave_display_idle),
        .rise  (idle_rise)
    );

    // Positive-going zero crossing: previous sample negative, current non-negative.
    assign trigger = prev_sample[SAMPLE_W-1] & ~new_sample_in[SAMPLE_W-1];
    assign forced  = TO_EN && (timeout_cnt == TO_LAST);

    always_comb begin
        state_next      = state;
        offset_next     = offset;
        decim_next      = decim_cnt;
        timeout_next    = timeout_cnt;
        read_index_next = read_index;
        we_next         = 1'b0;
        addr_next       = write_address;
        sample_next     = write_sample;
        prev_next       = new_sample_ready ? new_sample_in : prev_sample;

        case (state)
            ARMED: begin
                if (new_sample_ready) begin
                    if (trigger || forced) begin
                        we_next      = 1'b1;
                        addr_next    = {~read_index, {WAVE_OFFSET_W{1'b0}}};
                        sample_next  = to_display_sample(new_sample_in);
                        offset_next  = WAVE_OFFSET_W'(1);
                        decim_next   = 4'd0;
                        timeout_next = '0;
                        state_next   = ACTIVE;
                    end else begin
                        timeout_next = timeout_cnt + 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (new_sample_ready) begin
                    if (decim_cnt == DEC_LAST) begin
                        decim_next  = 4'd0;
                        we_next     = 1'b1;
                        addr_next   = {~read_index, offset};
                        sample_next = to_display_sample(new_sample_in);
                        // Offset wraps to 0 after the last slot; WAIT stops further writes.
                        offset_next = offset + 1'b1;
                        if (offset == {WAVE_OFFSET_W{1'b1}}) begin
                            state_next = WAIT;
                        end
                    end else begin
                        decim_next = decim_cnt + 1'b1;
                    end
                end
            end
            WAIT: begin
                // Only a fresh 0->1 idle edge hands the new buffer to the display,
                // so each frame sees at most one flip.
                if (idle_rise) begin
                    read_index_next = ~read_index;
                    timeout_next    = '0;
                    state_next      = ARMED;
                end
            end
            default: begin
                state_next = ARMED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ARMED;
            offset        <= '0;
            decim_cnt     <= '0;
            timeout_cnt   <= '0;
            prev_sample   <= '0;
            read_index    <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_sample  <= '0;
            capturing     <= 1'b0;
        end else begin
            state         <= state_next;
            offset        <= offset_next;
            decim_cnt     <= decim_next;
            timeout_cnt   <= timeout_next;
            prev_sample   <= prev_next;
            read_index    <= read_index_next;
            write_enable  <= we_next;
            write_address <= addr_next;
            write_sample  <= sample_next;
            capturing     <= (state_next == ACTIVE);
        end
    end

endmodule

// File: tb/tb_wave_capture.sv
// tb_wave_capture: self-checking bench for wave_capture.
// Three instances share stimulus: DECIMATE=1/TIMEOUT=4096, DECIMATE=4/TIMEOUT=0,
// DECIMATE=1/TIMEOUT=16. Each test resets everything and observes one instance.
module tb_wave_capture;

    localparam int W = 33;  // {sample index[15:0], address[8:0], data[7:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        new_sample_ready = 1'b0;
    logic [15:0] new_sample_in = 16'h0;
    logic        wave_display_idle = 1'b0;

    logic [8:0] wa  [3];
    logic       we  [3];
    logic [7:0] ws  [3];
    logic       ri  [3];
    logic       cap [3];

    wave_capture #(.DECIMATE(1), .TIMEOUT(4096)) u_d1 (
        .clk(clk), .reset(reset), .new_sample_ready(new_sample_ready),
        .new_sample_in(new_sample_in), .wave_display_idle(wave_display_idle),
        .write_address(wa[0]), .write_enable(we[0]), .write_sample(ws[0]),
        .read_index(ri[0]), .capturing(cap[0])
    );
    wave_capture #(.DECIMATE(4), .TIMEOUT(0)) u_d4 (
        .clk(clk), .reset(reset), .new_sample_ready(new_sample_ready),
        .new_sample_in(new_sample_in), .wave_display_idle(wave_display_idle),
        .write_address(wa[1]), .write_enable(we[1]), .write_sample(ws[1]),
        .read_index(ri[1]), .capturing(cap[1])
    );
    wave_capture #(.DECIMATE(1), .TIMEOUT(16)) u_to (
        .clk(clk), .reset(reset), .new_sample_ready(new_sample_ready),
        .new_sample_in(new_sample_in), .wave_display_idle(wave_display_idle),
        .write_address(wa[2]), .write_enable(we[2]), .write_sample(ws[2]),
        .read_index(ri[2]), .capturing(cap[2])
    );

    // ---------------- bench state ----------------
    int         sel = 0;
    int         n_driven = 0;
    int         samp[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    // Write monitor: sampled on the falling edge, tagged with the index of the
    // sample that caused it.
    always @(negedge clk) begin
        if (we[sel]) obs_q.push_back({16'(n_driven - 1), wa[sel], ws[sel]});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        new_sample_ready = 1'b0;
        new_sample_in = 16'h0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic start_capture();
        samp.delete();
        obs_q.delete();
        exp_q.delete();
        n_driven = 0;
    endtask

    task automatic drive_sample(input int s, input int gap);
        new_sample_in = 16'(s);
        new_sample_ready = 1'b1;
        samp.push_back(s);
        @(posedge clk);
        #1;
        new_sample_ready = 1'b0;
        n_driven++;
        for (int g = 0; g < gap; g++) tick();
    endtask

    task automatic drive_rand(input int count, input int max_gap);
        logic signed [15:0] r;
        int s;
        for (int i = 0; i < count; i++) begin
            r = 16'($urandom);
            s = r;
            drive_sample(s, $urandom_range(0, max_gap));
        end
    endtask

    // ---------------- reference model ----------------
    // From the recorded stream of one capture: find the trigger (crossing from
    // negative to non-negative, or the TIMEOUT-th sample spent armed), then the
    // k-th kept sample lies k*DECIMATE samples after it and lands at offset k.
    task automatic build_exp(input int dec, input int tmo, input logic half, input int prev0);
        int t;
        int p;
        int idx;
        logic [7:0] d;
        t = -1;
        exp_q.delete();
        for (int i = 0; i < samp.size(); i++) begin
            p = (i == 0) ? prev0 : samp[i-1];
            if ((p < 0 && samp[i] >= 0) || (tmo != 0 && i == tmo - 1)) begin
                t = i;
                break;
            end
        end
        if (t >= 0) begin
            for (int k = 0; k < 256; k++) begin
                idx = t + k * dec;
                if (idx < samp.size()) begin
                    d = 8'((samp[idx] + 32768) / 256);
                    exp_q.push_back({16'(idx), half, 8'(k), d});
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        new_sample_ready = 1'b1;
        new_sample_in = 16'h0123;
        wave_display_idle = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({wa[i], we[i], ws[i], ri[i], cap[i]} !== 20'h0) begin
                n_err++;
                $display("FAIL reset_outputs[%0d]: got wa=%h we=%b ws=%h ri=%b cap=%b, want all 0",
                         i, wa[i], we[i], ws[i], ri[i], cap[i]);
            end
        end
        new_sample_ready = 1'b0;
        wave_display_idle = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_trigger();
        logic [W-1:0] got;
        do_reset();
        sel = 0;
        wave_display_idle = 1'b0;
        start_capture();
        drive_sample(-100, 1);
        drive_sample(-1, 1);
        n_vec++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL trig_early_write: got %0d writes, want 0", obs_q.size());
        end
        drive_sample(5, 0);
        n_vec++;
        if ({we[0], wa[0], ws[0], cap[0]} !== {1'b1, 9'h100, 8'h80, 1'b1}) begin
            n_err++;
            $display("FAIL trig_first_write: got we=%b wa=%h ws=%h cap=%b, want we=1 wa=100 ws=80 cap=1",
                     we[0], wa[0], ws[0], cap[0]);
        end
        drive_rand(100, 2);
        n_vec++;
        if (cap[0] !== 1'b1) begin
            n_err++;
            $display("FAIL trig_capturing_mid: got %b want 1", cap[0]);
        end
        drive_rand(200, 2);
        n_vec++;
        if ({cap[0], ri[0]} !== 2'b00) begin
            n_err++;
            $display("FAIL trig_done_status: got cap=%b ri=%b want 0 0", cap[0], ri[0]);
        end
        build_exp(1, 4096, 1'b1, 0);
        n_vec++;
        if (obs_q.size() != 256 || exp_q.size() != 256) begin
            n_err++;
            $display("FAIL trig_write_count: got %0d want 256 (model %0d)", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = 'x;
            if (i < obs_q.size()) got = obs_q[i];
            n_vec++;
            if (got !== exp_q[i]) begin
                n_err++;
                $display("FAIL trig_write[%0d]: got %h want %h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_handoff();
        logic [W-1:0] got;
        int last;
        do_reset();
        sel = 0;
        wave_display_idle = 1'b1;
        start_capture();
        drive_sample(-200, 0);
        drive_sample(17, 1);
        drive_rand(300, 1);
        build_exp(1, 4096, 1'b1, 0);
        // Samples arriving in WAIT, including a crossing, must not write.
        drive_sample(-5, 1);
        drive_sample(9, 1);
        repeat (4) tick();
        n_vec++;
        if (obs_q.size() != 256) begin
            n_err++;
            $display("FAIL handoff_first_count: got %0d want 256", obs_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = 'x;
            if (i < obs_q.size()) got = obs_q[i];
            n_vec++;
            if (got !== exp_q[i]) begin
                n_err++;
                $display("FAIL handoff_first_write[%0d]: got %h want %h", i, got, exp_q[i]);
            end
        end
        n_vec++;
        if (ri[0] !== 1'b0) begin
            n_err++;
            $display("FAIL handoff_idle_held: got ri=%b want 0", ri[0]);
        end
        wave_display_idle = 1'b0;
        tick();
        n_vec++;
        if (ri[0] !== 1'b0) begin
            n_err++;
            $display("FAIL handoff_idle_low: got ri=%b want 0", ri[0]);
        end
        wave_display_idle = 1'b1;
        tick();
        n_vec++;
        if ({ri[0], cap[0], we[0]} !== 3'b100) begin
            n_err++;
            $display("FAIL handoff_flip: got ri=%b cap=%b we=%b want 1 0 0", ri[0], cap[0], we[0]);
        end
        last = samp[samp.size()-1];
        start_capture();
        drive_sample(-300, 1);
        drive_sample(40, 1);
        drive_rand(260, 2);
        build_exp(1, 4096, 1'b0, last);
        n_vec++;
        if (obs_q.size() != 256 || exp_q.size() != 256) begin
            n_err++;
            $display("FAIL handoff_second_count: got %0d want 256 (model %0d)", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = 'x;
            if (i < obs_q.size()) got = obs_q[i];
            n_vec++;
            if (got !== exp_q[i]) begin
                n_err++;
                $display("FAIL handoff_second_write[%0d]: got %h want %h", i, got, exp_q[i]);
            end
        end
        wave_display_idle = 1'b0;
    endtask

    task automatic test_decimate();
        logic [W-1:0] got;
        int step;
        int start;
        int span;
        do_reset();
        sel = 1;
        wave_display_idle = 1'b0;
        start_capture();
        step  = $urandom_range(1, 8);
        start = -step * $urandom_range(20, 300);
        for (int i = 0; i < 1340; i++) drive_sample(start + i * step, $urandom_range(0, 1));
        repeat (3) tick();
        build_exp(4, 0, 1'b1, 0);
        n_vec++;
        if (obs_q.size() != 256 || exp_q.size() != 256) begin
            n_err++;
            $display("FAIL dec_write_count: got %0d want 256 (model %0d)", obs_q.size(), exp_q.size());
        end
        if (obs_q.size() >= 256) begin
            span = int'(obs_q[255][32:17]) - int'(obs_q[0][32:17]);
            n_vec++;
            if (span != 255 * 4) begin
                n_err++;
                $display("FAIL dec_span: got %0d samples trigger->offset255, want %0d", span, 255 * 4);
            end
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = 'x;
            if (i < obs_q.size()) got = obs_q[i];
            n_vec++;
            if (got !== exp_q[i]) begin
                n_err++;
                $display("FAIL dec_write[%0d]: got %h want %h", i, got, exp_q[i]);
            end
        end
        n_vec++;
        if (cap[1] !== 1'b0) begin
            n_err++;
            $display("FAIL dec_done_capturing: got %b want 0", cap[1]);
        end
    endtask

    task automatic test_timeout();
        logic [W-1:0] got;
        do_reset();
        sel = 2;
        wave_display_idle = 1'b0;
        start_capture();
        for (int i = 0; i < 15; i++) drive_sample(1000, $urandom_range(0, 2));
        repeat (2) tick();
        n_vec++;
        if (obs_q.size() != 0 || cap[2] !== 1'b0) begin
            n_err++;
            $display("FAIL to_early: got %0d writes cap=%b want 0 writes cap=0", obs_q.size(), cap[2]);
        end
        drive_sample(1000, 0);
        n_vec++;
        if ({we[2], wa[2], ws[2]} !== {1'b1, 9'h100, 8'h83}) begin
            n_err++;
            $display("FAIL to_forced_write: got we=%b wa=%h ws=%h want we=1 wa=100 ws=83", we[2], wa[2], ws[2]);
        end
        for (int i = 0; i < 270; i++) drive_sample(1000, $urandom_range(0, 1));
        repeat (2) tick();
        build_exp(1, 16, 1'b1, 0);
        n_vec++;
        if (obs_q.size() != 256 || exp_q.size() != 256) begin
            n_err++;
            $display("FAIL to_write_count: got %0d want 256 (model %0d)", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = 'x;
            if (i < obs_q.size()) got = obs_q[i];
            n_vec++;
            if (got !== exp_q[i]) begin
                n_err++;
                $display("FAIL to_write[%0d]: got %h want %h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] got;
        logic signed [15:0] r;
        bit hit;
        do_reset();
        sel = 0;
        wave_display_idle = 1'b0;
        start_capture();
        drive_sample(-7, 0);
        drive_sample(3, 0);
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            r = 16'($urandom);
            drive_sample(int'(r), 0);
            if (we[0] === 1'b1 && wa[0][7:0] === 8'd100) hit = 1'b1;
        end
        n_vec++;
        if (!hit) begin
            n_err++;
            $display("FAIL rst_mid_reach100: got no write at offset 100 within 400 samples, want one");
        end
        reset = 1'b1;
        tick();
        n_vec++;
        if ({wa[0], we[0], ws[0], ri[0], cap[0]} !== 20'h0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got wa=%h we=%b ws=%h ri=%b cap=%b want all 0",
                     wa[0], we[0], ws[0], ri[0], cap[0]);
        end
        reset = 1'b0;
        start_capture();
        drive_sample(-5, 1);
        drive_sample(12, 1);
        drive_rand(270, 2);
        build_exp(1, 4096, 1'b1, 0);
        n_vec++;
        if (obs_q.size() != 256 || exp_q.size() != 256) begin
            n_err++;
            $display("FAIL rst_mid_count: got %0d want 256 (model %0d)", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = 'x;
            if (i < obs_q.size()) got = obs_q[i];
            n_vec++;
            if (got !== exp_q[i]) begin
                n_err++;
                $display("FAIL rst_mid_write[%0d]: got %h want %h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        sel = 0;
        wave_display_idle = 1'b0;
        start_capture();
        drive_sample(-9, 1);
        drive_sample(4, 1);
        drive_rand(300, 2);
        drive_sample(-20, 1);
        // Crossing sample and idle rising edge in the same cycle.
        wave_display_idle = 1'b1;
        drive_sample(25, 0);
        n_vec++;
        if ({ri[0], we[0], cap[0]} !== 3'b100) begin
            n_err++;
            $display("FAIL simul_flip: got ri=%b we=%b cap=%b want 1 0 0", ri[0], we[0], cap[0]);
        end
        // prev_sample now holds +25, so +6 is not a crossing.
        drive_sample(6, 0);
        n_vec++;
        if (we[0] !== 1'b0) begin
            n_err++;
            $display("FAIL simul_prev_updated: got we=%b want 0", we[0]);
        end
        drive_sample(-3, 0);
        n_vec++;
        if (we[0] !== 1'b0) begin
            n_err++;
            $display("FAIL simul_neg_no_trig: got we=%b want 0", we[0]);
        end
        drive_sample(6, 0);
        n_vec++;
        if ({we[0], wa[0], ws[0], cap[0]} !== {1'b1, 9'h000, 8'h80, 1'b1}) begin
            n_err++;
            $display("FAIL simul_next_trigger: got we=%b wa=%h ws=%h cap=%b want we=1 wa=000 ws=80 cap=1",
                     we[0], wa[0], ws[0], cap[0]);
        end
        wave_display_idle = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_trigger();
        test_handoff();
        test_decimate();
        test_timeout();
        test_reset_mid();
        test_simultaneous();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wave_capture.md
Name: wave_capture

Overview:
- Upstream producer for the waveform display RAM.
- Watches the audio sample stream and arms on a positive-going zero crossing.
- Writes 256 consecutive (optionally decimated) 8-bit samples into the half of a 512-entry double-buffered RAM not currently being displayed.
- After a frame boundary, flips read_index so the display reader (9-bit address {read_index, offset}) shows the fresh capture.

Parameters:
- DECIMATE, 1: keep every DECIMATE-th sample while capturing; legal range 1..16.
- TIMEOUT, 4096: samples spent in ARMED without a trigger before a forced capture starts; 0 disables the forced capture.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- new_sample_ready  input  1  one-cycle strobe; new_sample_in is valid on this cycle
- new_sample_in  input  16  signed two's-complement audio sample
- wave_display_idle  input  1  level; high while the display is outside the active drawing region
- write_address  output  9  RAM write address {~read_index, offset[7:0]}
- write_enable  output  1  one-cycle RAM write strobe
- write_sample  output  8  unsigned sample {~new_sample_in[15], new_sample_in[14:8]}
- read_index  output  1  half of the RAM that the display reads
- capturing  output  1  high while in ACTIVE (status only)

Behaviour:
- Reset values: state ARMED; read_index 0; write_enable 0; write_address 0; write_sample 0; capturing 0; prev_sample 0; offset 0; decim_cnt 0; timeout_cnt 0; idle edge register 0.
- Outputs are registered. write_enable/write_address/write_sample are driven the cycle after the accepted new_sample_ready.
- prev_sample loads new_sample_in on every new_sample_ready, in all states.
- Trigger condition, evaluated on new_sample_ready: prev_sample[15]==1 and new_sample_in[15]==0.
- ARMED:
  - On trigger: write the triggering sample at offset 0 and go to ACTIVE with offset=1 and decim_cnt=0.
  - Otherwise timeout_cnt increments per sample. If TIMEOUT!=0 and timeout_cnt==TIMEOUT-1 on a sample, treat that sample as the trigger.
  - timeout_cnt clears on entry to ARMED and on trigger.
- ACTIVE:
  - Each new_sample_ready increments decim_cnt mod DECIMATE.
  - The sample is written only when decim_cnt==DECIMATE-1 (DECIMATE=1: every sample), at the current offset; offset then increments.
  - The write at offset 255 moves the block to WAIT. Offset wraps to 0 internally and is never written twice per capture.
- WAIT:
  - No writes; incoming samples are ignored except for updating prev_sample.
  - On a rising edge of wave_display_idle (registered 0 to current 1), toggle read_index and go to ARMED.
  - An idle level already high on entry to WAIT does not flip; the block waits for the next rising edge. This guarantees one flip per frame.
- The write half is always ~read_index, so the displayed half is never written.
- new_sample_ready and an idle rising edge in the same cycle in WAIT: flip takes priority; that sample is not a trigger candidate, but prev_sample still updates.
- Reset asserted mid-capture: all state returns to reset values next cycle. Partial buffer contents are don't-care.
- capturing = (state==ACTIVE), registered.

Decomposition:
- Shared package wave_pkg:
  - state encoding ARMED=2'd0, ACTIVE=2'd1, WAIT=2'd2
  - WAVE_OFFSET_W=8, WAVE_ADDR_W=9, SAMPLE_W=16, DISP_SAMPLE_W=8
  - to_display_sample conversion function, also used by the display side
- One sub-module, edge_detect_rise: registered rising-edge detector for wave_display_idle, reset to 0.

Test Plan:
- Trigger: samples -100, -1, +5, +7, ... with DECIMATE=1 → first write at address {1,8'd0} with data 8'h80; subsequent writes at offsets 1,2,…; exactly 256 write_enable pulses; capturing is high throughout.
- Display handoff: capture done, wave_display_idle held high before WAIT entry, then toggled 0→1 → read_index flips 0→1 only on the 0→1 edge; the next capture writes addresses 0..255.
- Decimation: DECIMATE=4, ramp input → after the trigger, writes occur on every 4th sample; offset 255 is reached after 1+255×4 samples following the trigger.
- Timeout: TIMEOUT=16, constant input +1000 → forced capture starts on the 16th sample; write_sample is 8'h83.
- Reset mid-capture: reset pulsed at offset 100 → next cycle all outputs are 0 and state is ARMED; a subsequent trigger writes from offset 0 into half 1.
- Simultaneous events: in WAIT, new_sample_ready with a crossing coincides with an idle rising edge → read_index toggles, no write that cycle, state ARMED; the next crossing triggers normally.
